// File: rtl/nibble_serial_add_ctrl.sv
// Multi-word adder that reuses one 4-bit ripple slice over WIDTH/4 cycles, with the carry held in a register between nibbles.
// Defining NIBBLE_SERIAL_SUB_EN adds the op_sub port, which selects a - b instead of a + b + cin.

module ripple_adder_4bit_dataflow (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g    = a & b;
    assign w_p    = a ^ b;
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_c[1]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_c[2]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_c[3]);
    assign sum    = w_p ^ w_c[3:0];
    assign cout   = w_c[4];
endmodule

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_bad_width
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [3:0]       w_slice_a;
    logic [3:0]       w_slice_b;
    logic [3:0]       w_slice_sum;
    logic             w_slice_cout;

    // Operand B and initial carry as they will be latched on accept (subtract = a + ~b + 1).
    always_comb begin
        w_b_eff   = b;
        w_cin_eff = cin;
`ifdef NIBBLE_SERIAL_SUB_EN
        if (op_sub) begin
            w_b_eff   = ~b;
            w_cin_eff = 1'b1;
        end else begin
            w_b_eff   = b;
            w_cin_eff = cin;
        end
`endif
    end

    assign w_slice_a = r_a[4*r_idx +: 4];
    assign w_slice_b = r_b[4*r_idx +: 4];

    ripple_adder_4bit_dataflow u_slice (
        .a    (w_slice_a),
        .b    (w_slice_b),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // Sequencer: accept operands, walk the nibbles low to high, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= w_b_eff;
                        r_carry    <= w_cin_eff;
                        r_sum      <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sum[4*r_idx +: 4] <= w_slice_sum;
                    r_carry             <= w_slice_cout;
                    if (r_idx == LAST_IDX) begin
                        r_idx       <= '0;
                        r_cout      <= w_slice_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_idx       <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl at WIDTH=16; subtract cases run when NIBBLE_SERIAL_SUB_EN is defined.

module tb_nibble_serial_add_ctrl;
    localparam int NIB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
`ifdef NIBBLE_SERIAL_SUB_EN
    logic        op_sub;
`endif

    logic [16:0] sb[$];
    int total = 0;
    int bad   = 0;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NIBBLE_SERIAL_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Drive one request for one edge and record its expected {cout,sum}.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic isub);
        logic [16:0] e;
        a   = ia;
        b   = ib;
        cin = ic;
`ifdef NIBBLE_SERIAL_SUB_EN
        op_sub = isub;
`endif
        if (isub) e = {1'b0, ia} + {1'b0, ~ib} + 17'd1;
        else      e = {1'b0, ia} + {1'b0, ib} + {16'd0, ic};
        sb.push_back(e);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic ok, output logic [16:0] got, output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        ok  = (out_valid === 1'b1);
        got = {cout, sum};
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
        op_sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        total++;
        if ({out_valid, in_ready, busy, cout, sum} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL reset_state got ov=%b ir=%b busy=%b cout=%b sum=%h", out_valid, in_ready, busy, cout, sum);
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1; out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL idle_out_ready got ov=%b ir=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_basic();
        logic [16:0] e;
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        for (int k = 0; k < NIB; k++) begin
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL basic_run_k%0d got ov=%b busy=%b ir=%b expected 0 1 0", k, out_valid, busy, in_ready);
            end
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        total++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || {cout, sum} !== e) begin
            bad++;
            $display("FAIL basic_result got ov=%b busy=%b res=%h expected 1 1 %h", out_valid, busy, {cout, sum}, e);
        end
        total++;
        if ({cout, sum} !== 17'h0_5555) begin
            bad++;
            $display("FAIL basic_const got %h expected 05555", {cout, sum});
        end
        handoff();
    endtask

    task automatic test_carry();
        logic [15:0] ta[2] = '{16'hFFFF, 16'h000F};
        logic [15:0] tb[2] = '{16'h0001, 16'h0000};
        logic        tc[2] = '{1'b0, 1'b1};
        logic        ok;
        logic [16:0] got;
        logic [16:0] e;
        int          cyc;
        for (int i = 0; i < 2; i++) begin
            issue(ta[i], tb[i], tc[i], 1'b0);
            wait_out(ok, got, cyc);
            e = sb.pop_front();
            total++;
            if (!ok || cyc != NIB || got !== e) begin
                bad++;
                $display("FAIL carry_%0d got res=%h lat=%0d ok=%b expected %h lat=%0d", i, got, cyc, ok, e, NIB);
            end
            handoff();
        end
    endtask

    task automatic test_backpressure();
        logic        ok;
        logic [16:0] got;
        logic [16:0] e;
        int          cyc;
        issue(16'hABCD, 16'h1357, 1'b1, 1'b0);
        wait_out(ok, got, cyc);
        e = sb.pop_front();
        total++;
        if (!ok || got !== e) begin
            bad++;
            $display("FAIL bp_result got %h ok=%b expected %h", got, ok, e);
        end
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== e) begin
                bad++;
                $display("FAIL bp_hold_%0d got ov=%b ir=%b res=%h expected 1 0 %h", k, out_valid, in_ready, {cout, sum}, e);
            end
        end
        handoff();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_release got ir=%b ov=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
        end
        issue(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
        wait_out(ok, got, cyc);
        e = sb.pop_front();
        total++;
        if (!ok || cyc != NIB || got !== e) begin
            bad++;
            $display("FAIL bp_next got %h lat=%0d expected %h", got, cyc, e);
        end
        handoff();
    endtask

    task automatic test_isolation();
        logic [16:0] e;
        issue(16'h8421, 16'h7BDE, 1'b1, 1'b0);
        in_valid = 1'b1;
        for (int k = 0; k < NIB; k++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        total++;
        if (out_valid !== 1'b1 || {cout, sum} !== e) begin
            bad++;
            $display("FAIL isolation got ov=%b res=%h expected 1 %h", out_valid, {cout, sum}, e);
        end
        handoff();
    endtask

    task automatic test_reset_mid_op();
        logic        ok;
        logic [16:0] got;
        logic [16:0] e;
        int          cyc;
        logic        seen;
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        total++;
        if ({out_valid, in_ready, busy, cout, sum} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL midrst_state got ov=%b ir=%b busy=%b cout=%b sum=%h", out_valid, in_ready, busy, cout, sum);
        end
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL midrst_no_valid got out_valid seen=%b expected 0", seen);
        end
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
        wait_out(ok, got, cyc);
        e = sb.pop_front();
        total++;
        if (!ok || got !== e || got !== 17'h0_0100) begin
            bad++;
            $display("FAIL midrst_next got %h ok=%b expected %h", got, ok, e);
        end
        handoff();
    endtask

`ifdef NIBBLE_SERIAL_SUB_EN
    task automatic test_sub();
        logic [15:0] ta[3] = '{16'h0007, 16'h0005, 16'h1234};
        logic [15:0] tb[3] = '{16'h0005, 16'h0007, 16'h1111};
        logic        ts[3] = '{1'b1, 1'b1, 1'b0};
        logic        ok;
        logic [16:0] got;
        logic [16:0] e;
        int          cyc;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i], 1'b0, ts[i]);
            wait_out(ok, got, cyc);
            e = sb.pop_front();
            total++;
            if (!ok || cyc != NIB || got !== e) begin
                bad++;
                $display("FAIL sub_%0d got %h lat=%0d expected %h lat=%0d", i, got, cyc, e, NIB);
            end
            handoff();
        end
        op_sub = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        logic        ok;
        logic [16:0] got;
        logic [16:0] e;
        int          cyc;
        for (int i = 0; i < 10; i++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            wait_out(ok, got, cyc);
            e = sb.pop_front();
            total++;
            if (!ok || cyc != NIB || got !== e) begin
                bad++;
                $display("FAIL b2b_%0d got %h lat=%0d ok=%b expected %h", i, got, cyc, ok, e);
            end
            handoff();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_isolation();
        test_reset_mid_op();
`ifdef NIBBLE_SERIAL_SUB_EN
        test_sub();
`endif
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
